// File: rtl/sa_pkg.sv
// ----------------------------------------------------------------------------
// sa_pkg
// Shared types and default sizing for the serial-add receive path.
//   sa_state_e : deserializer FSM states
//   SA_WIDTH   : default result width (serial bits per frame)
//   SA_CNT_W   : default bit-counter width (2**SA_CNT_W must exceed SA_WIDTH)
// ----------------------------------------------------------------------------
package sa_pkg;

    // state | meaning
    // IDLE  | waiting for a frame's first (LSB) bit
    // SHIFT | frame in progress, collecting bits 1..WIDTH-1
    // HOLD  | full word held on out_sum/out_cout, waiting for out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } sa_state_e;

    localparam int SA_WIDTH = 4;
    localparam int SA_CNT_W = 3;

endpackage

// File: rtl/sa_deser.sv
// ----------------------------------------------------------------------------
// sa_deser
// Receive end of the serial adder: gathers LSB-first sum bits and the final
// carry from the 1-bit full adder into a parallel word, then offers it
// downstream on a valid/ready handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   s_valid    in   serial inputs valid this cycle
//   s_bit      in   serial sum bit, LSB first
//   s_carry    in   adder carry after this bit
//   s_first    in   marks bit 0 of a frame
//   out_ready  in   downstream accepts the held word
//   out_valid  out  word held and valid
//   out_sum    out  assembled sum, bit i = i-th received bit
//   out_cout   out  carry sampled with the last bit
//   busy       out  frame in progress
//   frame_err  out  1-cycle pulse: s_first seen mid-frame
//   overrun    out  1-cycle pulse: input dropped while a word is held
// ----------------------------------------------------------------------------
module sa_deser
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int CNT_W = SA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_bit,
    input  logic             s_carry,
    input  logic             s_first,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    sa_state_e        state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;
    logic             err_nxt;
    logic             ovr_nxt;
    logic             load;
    logic             start;

    assign start = s_valid & s_first;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        sum_nxt   = out_sum;
        cout_nxt  = out_cout;
        err_nxt   = 1'b0;
        ovr_nxt   = 1'b0;
        load      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (s_valid) begin
                    if (s_first) begin
                        err_nxt = 1'b1;
                        load    = 1'b1;
                    end else begin
                        // Bits above count are zero since the frame start,
                        // so OR-ing the new bit in places it.
                        sum_nxt = out_sum | (WIDTH'(s_bit) << count);
                        if (count == LAST_IDX) begin
                            cout_nxt  = s_carry;
                            count_nxt = '0;
                            state_nxt = HOLD;
                        end else begin
                            count_nxt = count + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (s_valid) begin
                    ovr_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase

        // Frame start: clear the whole word so stale upper bits never leak.
        if (load) begin
            sum_nxt = WIDTH'(s_bit);
            if (WIDTH == 1) begin
                cout_nxt  = s_carry;
                count_nxt = '0;
                state_nxt = HOLD;
            end else begin
                count_nxt = CNT_W'(1);
                state_nxt = SHIFT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            out_sum   <= sum_nxt;
            out_cout  <= cout_nxt;
            out_valid <= (state_nxt == HOLD);
            busy      <= (state_nxt == SHIFT);
            frame_err <= err_nxt;
            overrun   <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_sa_deser.sv
module tb_sa_deser;

    localparam int W  = 4;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid, s_bit, s_carry, s_first, out_ready;
    logic         out_valid, out_cout, busy, frame_err, overrun;
    logic [W-1:0] out_sum;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is a list of received bits; the word is
    // their weighted sum once W bits have arrived.
    bit           m_in_frame;
    bit           m_held;
    bit           m_q[$];
    logic [W-1:0] m_sum;
    bit           m_cout;
    bit           m_err;
    bit           m_ovr;

    sa_deser #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_bit     (s_bit),
        .s_carry   (s_carry),
        .s_first   (s_first),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0;
        m_held     = 0;
        m_q.delete();
        m_err      = 0;
        m_ovr      = 0;
    endtask

    task automatic model_finish(input bit c);
        int word;
        word = 0;
        for (int i = 0; i < m_q.size(); i++) word += int'(m_q[i]) * (2 ** i);
        m_sum      = W'(word);
        m_cout     = c;
        m_held     = 1;
        m_in_frame = 0;
        m_q.delete();
    endtask

    task automatic model_start(input bit b, input bit c);
        m_q.delete();
        m_q.push_back(b);
        m_in_frame = 1;
        if (W == 1) model_finish(c);
    endtask

    task automatic model_step(input bit v, input bit f, input bit b, input bit c, input bit r);
        m_err = 0;
        m_ovr = 0;
        if (m_held) begin
            if (r) begin
                m_held = 0;
                if (v && f) model_start(b, c);
            end else if (v) begin
                m_ovr = 1;
            end
        end else if (m_in_frame) begin
            if (v) begin
                if (f) begin
                    m_err = 1;
                    model_start(b, c);
                end else begin
                    m_q.push_back(b);
                    if (m_q.size() == W) model_finish(c);
                end
            end
        end else if (v && f) begin
            model_start(b, c);
        end
    endtask

    task automatic compare_all();
        check_val("out_valid", 32'(out_valid), 32'(m_held));
        check_val("busy", 32'(busy), 32'(m_in_frame));
        check_val("frame_err", 32'(frame_err), 32'(m_err));
        check_val("overrun", 32'(overrun), 32'(m_ovr));
        if (m_held) begin
            check_val("out_sum", 32'(out_sum), 32'(m_sum));
            check_val("out_cout", 32'(out_cout), 32'(m_cout));
        end
    endtask

    // One clock: drive on the falling edge, step the model at the rising
    // edge, compare just after it.
    task automatic cyc(input bit v, input bit f, input bit b, input bit c, input bit r);
        @(negedge clk);
        s_valid   = v;
        s_first   = f;
        s_bit     = b;
        s_carry   = c;
        out_ready = r;
        @(posedge clk);
        model_step(v, f, b, c, r);
        #1;
        compare_all();
    endtask

    task automatic send_frame(input logic [W-1:0] bits, input bit last_c, input bit r);
        for (int i = 0; i < W; i++)
            cyc(1'b1, i == 0, bits[i], (i == W - 1) ? last_c : 1'b0, r);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_sum"}, 32'(out_sum), 32'd0);
        check_val({tag, "_cout"}, 32'(out_cout), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_err"}, 32'(frame_err), 32'd0);
        check_val({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        s_valid   = 1'b0;
        s_bit     = 1'b0;
        s_carry   = 1'b0;
        s_first   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: basic frame 1,0,1,1 carry 1 on last bit
        send_frame(4'b1101, 1'b1, 1'b1);
        check_val("t1_sum", 32'(out_sum), 32'hD);
        check_val("t1_cout", 32'(out_cout), 32'd1);
        check_val("t1_valid", 32'(out_valid), 32'd1);
        cyc(0, 0, 0, 0, 1);
        check_val("t1_idle", 32'(out_valid), 32'd0);

        // 2: stalled downstream, extra inputs overrun
        send_frame(4'b1101, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(i[0] == 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            check_val("t2_sum_held", 32'(out_sum), 32'hD);
            check_val("t2_valid_held", 32'(out_valid), 32'd1);
            check_val("t2_overrun", 32'(overrun), 32'(i[0] == 1'b0));
        end
        cyc(0, 0, 0, 0, 1);

        // 3: s_first again at bit 2 restarts; new frame 0,1,1,0
        cyc(1, 1, 1, 0, 1);
        cyc(1, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 1);
        check_val("t3_frame_err", 32'(frame_err), 32'd1);
        cyc(1, 0, 1, 0, 1);
        cyc(1, 0, 1, 0, 1);
        cyc(1, 0, 0, 1, 1);
        check_val("t3_sum", 32'(out_sum), 32'h6);
        cyc(0, 0, 0, 0, 1);

        // 4: reset in the middle of a frame
        cyc(1, 1, 1, 0, 1);
        cyc(1, 0, 1, 0, 1);
        @(negedge clk);
        s_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("t4_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        send_frame(4'b1000, 1'b0, 1'b1);
        check_val("t4_sum", 32'(out_sum), 32'h8);
        check_val("t4_cout", 32'(out_cout), 32'd0);

        // 5: back-to-back, next frame starts during the handshake cycle
        cyc(1, 1, 1, 0, 1);
        check_val("t5_no_bubble", 32'(busy), 32'd1);
        cyc(1, 0, 1, 0, 1);
        cyc(1, 0, 1, 0, 1);
        cyc(1, 0, 1, 1, 1);
        check_val("t5_sum", 32'(out_sum), 32'hF);
        check_val("t5_cout", 32'(out_cout), 32'd1);
        cyc(0, 0, 0, 0, 1);

        // 6: idle gap between every bit
        for (int i = 0; i < W; i++) begin
            cyc(1, i == 0, (4'b1011 >> i) & 1'b1, i == W - 1, 1);
            if (i < W - 1) begin
                cyc(0, 0, 1, 1, 1);
                check_val("t6_busy", 32'(busy), 32'd1);
            end
        end
        check_val("t6_sum", 32'(out_sum), 32'hB);
        check_val("t6_cout", 32'(out_cout), 32'd1);
        cyc(0, 0, 0, 0, 1);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 5) == 0,
                1'($urandom),
                1'($urandom),
                $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
